// File: rtl/nx_node_seq_if.sv
// Configuration, trigger and result bundle of one sequenced logic node.
// master drives program/trigger/inputs; slave (the node) returns outputs, busy and done.
interface nx_node_seq_if #(
  parameter int NUM_INPUTS  = 8,
  parameter int NUM_OUTPUTS = 8,
  parameter int IDX_W       = 3,
  parameter int INSTR_DEPTH = 16
);
  localparam int INSTR_W = 6 + 4 * IDX_W;
  localparam int ADDR_W  = (INSTR_DEPTH > 1) ? $clog2(INSTR_DEPTH) : 1;
  localparam int LEN_W   = $clog2(INSTR_DEPTH + 1);

  logic                   cfg_valid;
  logic [ADDR_W-1:0]      cfg_addr;
  logic [INSTR_W-1:0]     cfg_data;
  logic                   cfg_len_valid;
  logic [LEN_W-1:0]       cfg_len;
  logic                   trigger;
  logic [NUM_INPUTS-1:0]  inputs;
  logic [NUM_OUTPUTS-1:0] outputs;
  logic                   busy;
  logic                   done;

  modport master (
    output cfg_valid, cfg_addr, cfg_data, cfg_len_valid, cfg_len, trigger, inputs,
    input  outputs, busy, done
  );

  modport slave (
    input  cfg_valid, cfg_addr, cfg_data, cfg_len_valid, cfg_len, trigger, inputs,
    output outputs, busy, done
  );
endinterface

// File: rtl/nx_node_seq.sv
// Programmable mesh node: runs a stored sequence of 2-input logic instructions per trigger.
// Define NX_NODE_KEEP_REGS_EN to keep working registers across evaluations.
module nx_node_seq #(
  parameter int NUM_INPUTS  = 8,
  parameter int NUM_REGS    = 8,
  parameter int NUM_OUTPUTS = 8,
  parameter int IDX_W       = 3,
  parameter int INSTR_DEPTH = 16
) (
  input logic          clk,
  input logic          rst,
  nx_node_seq_if.slave bus
);
  // Word layout: op, is_input_a, src_a, is_input_b, src_b, target, out_en, out_idx.
  localparam int INSTR_W = 6 + 4 * IDX_W;
  localparam int ADDR_W  = (INSTR_DEPTH > 1) ? $clog2(INSTR_DEPTH) : 1;
  localparam int LEN_W   = $clog2(INSTR_DEPTH + 1);
  localparam int SEL_N   = 2 ** IDX_W;

  typedef enum logic {IDLE, EXEC} state_t;

  state_t                 state;
  logic [INSTR_W-1:0]     store [INSTR_DEPTH];
  logic [LEN_W-1:0]       len;
  logic [ADDR_W-1:0]      pc;
  logic [NUM_INPUTS-1:0]  snapshot;
  logic [NUM_REGS-1:0]    regs;
  logic [NUM_OUTPUTS-1:0] stage;
  logic [NUM_OUTPUTS-1:0] outputs_q;
  logic                   busy_q;
  logic                   done_q;

  logic [INSTR_W-1:0]     instr;
  logic [2:0]             op;
  logic                   is_in_a;
  logic                   is_in_b;
  logic                   out_en;
  logic [IDX_W-1:0]       src_a;
  logic [IDX_W-1:0]       src_b;
  logic [IDX_W-1:0]       target;
  logic [IDX_W-1:0]       out_idx;
  logic [SEL_N-1:0]       in_pad;
  logic [SEL_N-1:0]       reg_pad;
  logic                   opa;
  logic                   opb;
  logic                   result;
  logic [NUM_REGS-1:0]    regs_next;
  logic [NUM_OUTPUTS-1:0] stage_next;
  logic [LEN_W-1:0]       cfg_len_sat;
  logic [LEN_W-1:0]       len_eff;
  logic                   last;

  assign bus.outputs = outputs_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;

  // A length written in the same cycle as an accepted trigger governs that evaluation.
  assign cfg_len_sat = (bus.cfg_len > LEN_W'(INSTR_DEPTH)) ? LEN_W'(INSTR_DEPTH) : bus.cfg_len;
  assign len_eff     = bus.cfg_len_valid ? cfg_len_sat : len;
  assign last        = (LEN_W'(pc) + LEN_W'(1)) == len;

  // Zero-padding the operand sources makes out-of-range indices read 0 for free.
  always_comb begin
    instr   = store[pc];
    op      = instr[2:0];
    is_in_a = instr[3];
    src_a   = instr[4 +: IDX_W];
    is_in_b = instr[4 + IDX_W];
    src_b   = instr[5 + IDX_W +: IDX_W];
    target  = instr[5 + 2 * IDX_W +: IDX_W];
    out_en  = instr[5 + 3 * IDX_W];
    out_idx = instr[6 + 3 * IDX_W +: IDX_W];
    in_pad  = SEL_N'(snapshot);
    reg_pad = SEL_N'(regs);
    opa     = is_in_a ? in_pad[src_a] : reg_pad[src_a];
    opb     = is_in_b ? in_pad[src_b] : reg_pad[src_b];
    result  = 1'b0;
    case (op)
      3'd0:    result = ~opa;
      3'd1:    result = opa & opb;
      3'd2:    result = ~(opa & opb);
      3'd3:    result = opa | opb;
      3'd4:    result = ~(opa | opb);
      3'd5:    result = opa ^ opb;
      3'd6:    result = ~(opa ^ opb);
      default: result = 1'b0;
    endcase
    regs_next = regs;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (target == IDX_W'(i)) regs_next[i] = result;
    end
    stage_next = stage;
    for (int j = 0; j < NUM_OUTPUTS; j++) begin
      if (out_en && (out_idx == IDX_W'(j))) stage_next[j] = result;
    end
  end

  // The instruction store survives reset; it only accepts writes while idle.
  always_ff @(posedge clk) begin
    if (state == IDLE && bus.cfg_valid) store[bus.cfg_addr] <= bus.cfg_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      len       <= '0;
      pc        <= '0;
      snapshot  <= '0;
      regs      <= '0;
      stage     <= '0;
      outputs_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.cfg_len_valid) len <= cfg_len_sat;
          if (bus.trigger) begin
            if (len_eff != '0) begin
              state    <= EXEC;
              busy_q   <= 1'b1;
              snapshot <= bus.inputs;
              stage    <= outputs_q;
              pc       <= '0;
`ifdef NX_NODE_KEEP_REGS_EN
              regs     <= regs;
`else
              regs     <= '0;
`endif
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        EXEC: begin
          regs  <= regs_next;
          stage <= stage_next;
          pc    <= pc + ADDR_W'(1);
          if (last) begin
            outputs_q <= stage_next;
            done_q    <= 1'b1;
            busy_q    <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_nx_node_seq.sv
// Self-checking bench for nx_node_seq against a sequential instruction-interpreter model.
// Built with NUM_REGS=6 so targets/sources 6 and 7 are out of range.
module tb_nx_node_seq;
  localparam int NIN   = 8;
  localparam int NREGS = 6;
  localparam int NOUT  = 8;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;

  logic [17:0] model_store [DEPTH];
  int          model_len;
  int          model_regs [NREGS];
  logic [7:0]  model_out;

  nx_node_seq_if #(.NUM_INPUTS(NIN), .NUM_OUTPUTS(NOUT), .IDX_W(3), .INSTR_DEPTH(DEPTH)) bus ();

  nx_node_seq #(
    .NUM_INPUTS(NIN), .NUM_REGS(NREGS), .NUM_OUTPUTS(NOUT), .IDX_W(3), .INSTR_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [17:0] mk(input int op, input int ia, input int sa, input int ib,
                                     input int sb, input int tgt, input int oen, input int oidx);
    return 18'(op + ia * 8 + sa * 16 + ib * 128 + sb * 256 + tgt * 2048 + oen * 16384 + oidx * 32768);
  endfunction

  task automatic model_reset();
    model_out = '0;
    model_len = 0;
    for (int i = 0; i < NREGS; i++) model_regs[i] = 0;
  endtask

  // One evaluation interpreted instruction by instruction with plain integer arithmetic.
  task automatic model_run(input logic [7:0] snap);
    int r [NREGS];
    logic [7:0] stg;
    int w, op, ia, sa, ib, sb, tgt, oen, oidx, a, b, res;
    if (model_len == 0) return;
    stg = model_out;
    for (int i = 0; i < NREGS; i++) begin
`ifdef NX_NODE_KEEP_REGS_EN
      r[i] = model_regs[i];
`else
      r[i] = 0;
`endif
    end
    for (int k = 0; k < model_len; k++) begin
      w = int'(model_store[k]);
      op = w % 8; ia = (w / 8) % 2; sa = (w / 16) % 8; ib = (w / 128) % 2;
      sb = (w / 256) % 8; tgt = (w / 2048) % 8; oen = (w / 16384) % 2; oidx = (w / 32768) % 8;
      a = ia ? ((sa < NIN) ? int'(snap[sa]) : 0) : ((sa < NREGS) ? r[sa] : 0);
      b = ib ? ((sb < NIN) ? int'(snap[sb]) : 0) : ((sb < NREGS) ? r[sb] : 0);
      case (op)
        0: res = 1 - a;
        1: res = a & b;
        2: res = 1 - (a & b);
        3: res = a | b;
        4: res = 1 - (a | b);
        5: res = a ^ b;
        6: res = 1 - (a ^ b);
        default: res = 0;
      endcase
      if (tgt < NREGS) r[tgt] = res;
      if (oen == 1 && oidx < NOUT) stg[oidx] = 1'(res);
    end
    for (int i = 0; i < NREGS; i++) model_regs[i] = r[i];
    model_out = stg;
  endtask

  task automatic write_word(input int addr, input logic [17:0] w);
    bus.cfg_valid = 1'b1; bus.cfg_addr = 4'(addr); bus.cfg_data = w;
    tick();
    bus.cfg_valid = 1'b0;
    model_store[addr] = w;
  endtask

  task automatic set_len(input int l);
    bus.cfg_len_valid = 1'b1; bus.cfg_len = 5'(l);
    tick();
    bus.cfg_len_valid = 1'b0;
    model_len = (l > DEPTH) ? DEPTH : l;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
  endtask

  // Triggers one evaluation and watches a bounded window; c=0 is just after the trigger edge.
  task automatic run_eval(input logic [7:0] in_val, output logic [7:0] got, output int done_at,
                          output int done_cnt, output int busy_cnt);
    int win;
    win = model_len + 3;
    bus.inputs = in_val; bus.trigger = 1'b1;
    tick();
    bus.trigger = 1'b0;
    done_at = -1; done_cnt = 0; busy_cnt = 0; got = '0;
    for (int c = 0; c < win; c++) begin
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        done_cnt++;
        if (done_at < 0) begin done_at = c; got = bus.outputs; end
      end
      tick();
    end
    model_run(in_val);
  endtask

  task automatic test_reset();
    bus.cfg_valid = 0; bus.cfg_addr = '0; bus.cfg_data = '0; bus.cfg_len_valid = 0;
    bus.cfg_len = '0; bus.trigger = 0; bus.inputs = '0;
    for (int i = 0; i < DEPTH; i++) model_store[i] = '0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    model_reset();
    tick();
    checks++; if (bus.outputs !== 8'h00) begin errors++; $display("[TB] FAIL reset_outputs: got %h expected 00", bus.outputs); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", bus.done); end
  endtask

  task automatic test_basic();
    logic [7:0] got; int dat, dcnt, bcnt;
    write_word(0, mk(1, 1, 0, 1, 1, 0, 0, 0));
    write_word(1, mk(0, 0, 0, 0, 0, 1, 1, 2));
    set_len(2);
    run_eval(8'h03, got, dat, dcnt, bcnt);
    checks++; if (got !== 8'h00) begin errors++; $display("[TB] FAIL basic_out_03: got %h expected 00", got); end
    checks++; if (dat !== 2) begin errors++; $display("[TB] FAIL basic_latency: got %0d expected 2", dat); end
    checks++; if (dcnt !== 1) begin errors++; $display("[TB] FAIL basic_done_pulses: got %0d expected 1", dcnt); end
    checks++; if (bcnt !== 2) begin errors++; $display("[TB] FAIL basic_busy_cycles: got %0d expected 2", bcnt); end
    run_eval(8'h01, got, dat, dcnt, bcnt);
    checks++; if (got !== 8'h04) begin errors++; $display("[TB] FAIL basic_out_01: got %h expected 04", got); end
    checks++; if (bus.outputs !== 8'h04) begin errors++; $display("[TB] FAIL basic_out_hold: got %h expected 04", bus.outputs); end
  endtask

  task automatic test_zero_len();
    logic [7:0] got; int dat, dcnt, bcnt;
    set_len(0);
    run_eval(8'hFF, got, dat, dcnt, bcnt);
    checks++; if (dat !== 0) begin errors++; $display("[TB] FAIL zero_len_done_at: got %0d expected 0", dat); end
    checks++; if (dcnt !== 1) begin errors++; $display("[TB] FAIL zero_len_done_pulses: got %0d expected 1", dcnt); end
    checks++; if (bcnt !== 0) begin errors++; $display("[TB] FAIL zero_len_busy: got %0d expected 0", bcnt); end
    checks++; if (got !== 8'h04) begin errors++; $display("[TB] FAIL zero_len_outputs: got %h expected 04", got); end
    set_len(2);
  endtask

  task automatic test_exec_interference();
    logic [7:0] got; int dat, dcnt, bcnt;
    bus.inputs = 8'h03; bus.trigger = 1'b1;
    tick();
    dat = -1; dcnt = 0; bcnt = 0; got = '0;
    for (int c = 0; c < 6; c++) begin
      if (bus.busy) bcnt++;
      if (bus.done) begin dcnt++; if (dat < 0) begin dat = c; got = bus.outputs; end end
      if (c == 0) begin
        bus.inputs = 8'h00; bus.trigger = 1'b1;
        bus.cfg_valid = 1'b1; bus.cfg_addr = 4'd1; bus.cfg_data = mk(3, 1, 5, 1, 6, 1, 1, 2);
        bus.cfg_len_valid = 1'b1; bus.cfg_len = 5'd5;
      end else begin
        bus.trigger = 1'b0; bus.cfg_valid = 1'b0; bus.cfg_len_valid = 1'b0;
      end
      tick();
    end
    model_run(8'h03);
    checks++; if (got !== 8'h00) begin errors++; $display("[TB] FAIL busy_snapshot_out: got %h expected 00", got); end
    checks++; if (dcnt !== 1) begin errors++; $display("[TB] FAIL busy_trigger_ignored: got %0d done pulses expected 1", dcnt); end
    checks++; if (dat !== 2) begin errors++; $display("[TB] FAIL busy_latency: got %0d expected 2", dat); end
    run_eval(8'h01, got, dat, dcnt, bcnt);
    checks++; if (got !== 8'h04) begin errors++; $display("[TB] FAIL busy_cfg_ignored: got %h expected 04", got); end
    checks++; if (dat !== 2) begin errors++; $display("[TB] FAIL busy_len_ignored: got %0d expected 2", dat); end
  endtask

  task automatic test_back_to_back();
    bus.inputs = 8'h03; bus.trigger = 1'b1;
    tick();
    bus.trigger = 1'b0;
    model_run(8'h03);
    tick(); tick();
    checks++; if (bus.done !== 1'b1 || bus.outputs !== 8'h00) begin errors++; $display("[TB] FAIL b2b_first: got done=%b out=%h expected done=1 out=00", bus.done, bus.outputs); end
    bus.inputs = 8'h01; bus.trigger = 1'b1;
    tick();
    bus.trigger = 1'b0;
    model_run(8'h01);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL b2b_accepted: got busy=%b expected 1", bus.busy); end
    tick(); tick();
    checks++; if (bus.done !== 1'b1 || bus.outputs !== 8'h04) begin errors++; $display("[TB] FAIL b2b_second: got done=%b out=%h expected done=1 out=04", bus.done, bus.outputs); end
  endtask

  task automatic test_cfg_with_trigger();
    logic [7:0] got; int dat, dcnt;
    logic [17:0] w;
    w = mk(3, 1, 2, 1, 3, 0, 1, 3);
    bus.cfg_valid = 1'b1; bus.cfg_addr = 4'd0; bus.cfg_data = w;
    bus.cfg_len_valid = 1'b1; bus.cfg_len = 5'd1;
    bus.trigger = 1'b1; bus.inputs = 8'h04;
    tick();
    bus.cfg_valid = 1'b0; bus.cfg_len_valid = 1'b0; bus.trigger = 1'b0;
    model_store[0] = w; model_len = 1;
    model_run(8'h04);
    dat = -1; dcnt = 0; got = '0;
    for (int c = 0; c < 4; c++) begin
      if (bus.done) begin dcnt++; if (dat < 0) begin dat = c; got = bus.outputs; end end
      tick();
    end
    checks++; if (dat !== 1) begin errors++; $display("[TB] FAIL cfg_trig_len: got done_at=%0d expected 1", dat); end
    checks++; if (got[3] !== 1'b1) begin errors++; $display("[TB] FAIL cfg_trig_word: got bit3=%b expected 1", got[3]); end
    checks++; if (got !== model_out) begin errors++; $display("[TB] FAIL cfg_trig_out: got %h expected %h", got, model_out); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] got; int dat, dcnt, bcnt;
    write_word(0, mk(3, 1, 0, 1, 1, 0, 1, 0));
    write_word(1, mk(5, 0, 0, 1, 2, 1, 1, 1));
    write_word(2, mk(2, 0, 1, 1, 3, 2, 1, 6));
    write_word(3, mk(0, 0, 2, 0, 0, 3, 1, 7));
    set_len(4);
    run_eval(8'h01, got, dat, dcnt, bcnt);
    bus.inputs = 8'hA5; bus.trigger = 1'b1;
    tick();
    bus.trigger = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    checks++; if (bus.outputs !== 8'h00) begin errors++; $display("[TB] FAIL midrst_outputs: got %h expected 00", bus.outputs); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL midrst_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("[TB] FAIL midrst_done: got %b expected 0", bus.done); end
    tick();
    checks++; if (bus.done !== 1'b0) begin errors++; $display("[TB] FAIL midrst_no_done: got %b expected 0", bus.done); end
    set_len(4);
    run_eval(8'hA5, got, dat, dcnt, bcnt);
    checks++; if (got !== model_out) begin errors++; $display("[TB] FAIL midrst_rerun: got %h expected %h", got, model_out); end
    checks++; if (dat !== 4) begin errors++; $display("[TB] FAIL midrst_latency: got %0d expected 4", dat); end
  endtask

  task automatic test_op7_target();
    logic [7:0] got; int dat, dcnt, bcnt;
    pulse_reset();
    write_word(0, mk(3, 1, 0, 1, 1, 3, 1, 7));
    write_word(1, mk(7, 1, 0, 1, 1, 3, 1, 7));
    write_word(2, mk(0, 0, 3, 0, 0, 2, 1, 6));
    write_word(3, mk(1, 1, 0, 1, 1, 7, 0, 0));
    write_word(4, mk(0, 0, 1, 0, 0, 0, 1, 5));
    write_word(5, mk(0, 0, 7, 0, 0, 4, 1, 4));
    set_len(6);
    run_eval(8'hFF, got, dat, dcnt, bcnt);
    checks++; if (got[7] !== 1'b0) begin errors++; $display("[TB] FAIL op7_result: got bit7=%b expected 0", got[7]); end
    checks++; if (got !== 8'h70) begin errors++; $display("[TB] FAIL op7_range_out: got %h expected 70", got); end
    checks++; if (got !== model_out) begin errors++; $display("[TB] FAIL op7_model: got %h expected %h", got, model_out); end
  endtask

  task automatic test_keep_regs();
    logic [7:0] got; int dat, dcnt, bcnt;
    logic exp2;
`ifdef NX_NODE_KEEP_REGS_EN
    exp2 = 1'b0;
`else
    exp2 = 1'b1;
`endif
    pulse_reset();
    write_word(0, mk(5, 0, 0, 1, 0, 0, 1, 0));
    set_len(1);
    run_eval(8'h01, got, dat, dcnt, bcnt);
    checks++; if (got[0] !== 1'b1) begin errors++; $display("[TB] FAIL keep_first: got %b expected 1", got[0]); end
    run_eval(8'h01, got, dat, dcnt, bcnt);
    checks++; if (got[0] !== exp2) begin errors++; $display("[TB] FAIL keep_second: got %b expected %b", got[0], exp2); end
    checks++; if (got !== model_out) begin errors++; $display("[TB] FAIL keep_model: got %h expected %h", got, model_out); end
  endtask

  task automatic test_random();
    logic [7:0] got, in_val; int dat, dcnt, bcnt, l, nw;
    for (int it = 0; it < 25; it++) begin
      l = int'($urandom_range(0, 20));
      nw = (l > DEPTH) ? DEPTH : l;
      for (int k = 0; k < nw; k++) write_word(k, 18'($urandom));
      set_len(l);
      in_val = 8'($urandom);
      run_eval(in_val, got, dat, dcnt, bcnt);
      checks++; if (got !== model_out) begin errors++; $display("[TB] FAIL rand_out[%0d]: got %h expected %h (len %0d)", it, got, model_out, l); end
      checks++; if (dat !== model_len || bcnt !== model_len) begin errors++; $display("[TB] FAIL rand_timing[%0d]: got done_at=%0d busy=%0d expected %0d", it, dat, bcnt, model_len); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_len();
    test_exec_interference();
    test_back_to_back();
    test_cfg_with_trigger();
    test_reset_mid();
    test_op7_target();
    test_keep_regs();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
